// File: rtl/mux32_rr_arbiter_pkg.sv
// Shared constants and types for the 32-way round-robin mux arbiter.
// State encoding, sizes and a one-hot helper.
package mux32_rr_arbiter_pkg;

    localparam int N            = 32;
    localparam int SEL_W        = 5;
    localparam int HOLD_W       = 8;
    localparam int MAX_HOLD_DEF = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    function automatic logic [N-1:0] onehot(input logic [SEL_W-1:0] idx);
        return {{(N-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/mux32_rr_arbiter_pick.sv
// Rotating priority picker: first set bit of req scanning from ptr upward.
// Rotate so ptr lands on bit 0, find the lowest set bit, add ptr back.
module rr_priority_pick
    import mux32_rr_arbiter_pkg::*;
(
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] idx,
    output logic             found
);

    logic [N-1:0]     rot;
    logic [SEL_W-1:0] enc;

    // rotate right by ptr, then lowest-index priority encode
    always_comb begin
        rot   = N'({req, req} >> ptr);
        enc   = '0;
        found = |req;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                enc = SEL_W'(i);
            end
        end
        idx = enc + ptr;
    end

endmodule

// File: rtl/mux32_rr_arbiter.sv
// Round-robin owner arbiter for the shared 32-input mux datapath.
// Registered select/grant/valid, bounded hold, preempt pulse on forced rotation.
module mux32_rr_arbiter
    import mux32_rr_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N-1:0]     req,
    output logic [SEL_W-1:0] select,
    output logic [N-1:0]     grant,
    output logic             valid,
    output logic             preempt
);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    state_e            state_q, state_d;
    logic [SEL_W-1:0]  ptr_q, ptr_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [SEL_W-1:0]  select_q, select_d;
    logic [N-1:0]      grant_q, grant_d;
    logic              valid_q, valid_d;
    logic              preempt_q, preempt_d;

    logic [SEL_W-1:0]  owner_nxt;
    logic [N-1:0]      others;
    logic              keep;
    logic [SEL_W-1:0]  norm_idx;
    logic              norm_found;
    logic [SEL_W-1:0]  rot_idx;
    logic              rot_found;

    // the owner is whoever select currently points at
    always_comb begin
        owner_nxt = select_q + 5'd1;
        others    = req & ~grant_q;
        keep      = req[select_q];
    end

    // idle search from the stored pointer
    rr_priority_pick u_pick_norm (
        .req   (req),
        .ptr   (ptr_q),
        .idx   (norm_idx),
        .found (norm_found)
    );

    // in-grant search: owner masked, scan starts just past the owner
    rr_priority_pick u_pick_rot (
        .req   (others),
        .ptr   (owner_nxt),
        .idx   (rot_idx),
        .found (rot_found)
    );

    // next-state and next-output decision
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        select_d  = select_q;
        grant_d   = grant_q;
        valid_d   = valid_q;
        preempt_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (norm_found) begin
                    state_d  = ST_GRANT;
                    select_d = norm_idx;
                    grant_d  = onehot(norm_idx);
                    valid_d  = 1'b1;
                    hold_d   = '0;
                end
            end
            ST_GRANT: begin
                if (!keep) begin
                    ptr_d  = owner_nxt;
                    hold_d = '0;
                    if (rot_found) begin
                        select_d = rot_idx;
                        grant_d  = onehot(rot_idx);
                    end else begin
                        state_d  = ST_IDLE;
                        select_d = '0;
                        grant_d  = '0;
                        valid_d  = 1'b0;
                    end
                end else if (rot_found && hold_q == HOLD_LAST) begin
                    ptr_d     = owner_nxt;
                    hold_d    = '0;
                    select_d  = rot_idx;
                    grant_d   = onehot(rot_idx);
                    preempt_d = 1'b1;
                end else if (rot_found) begin
                    hold_d = hold_q + 8'd1;
                end else begin
                    hold_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // state and registered outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            hold_q    <= '0;
            select_q  <= '0;
            grant_q   <= '0;
            valid_q   <= 1'b0;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            select_q  <= select_d;
            grant_q   <= grant_d;
            valid_q   <= valid_d;
            preempt_q <= preempt_d;
        end
    end

    assign select  = select_q;
    assign grant   = grant_q;
    assign valid   = valid_q;
    assign preempt = preempt_q;

endmodule

// File: tb/tb_mux32_rr_arbiter.sv
// Bench for mux32_rr_arbiter: directed scenarios then random request bursts,
// all compared every cycle against an owner/pointer reference model.
module tb_mux32_rr_arbiter;

    localparam int MAXH = 8;

    logic        clock;
    logic        reset;
    logic [31:0] req;
    logic [4:0]  select;
    logic [31:0] grant;
    logic        valid;
    logic        preempt;

    int checks   = 0;
    int failures = 0;

    int m_owner;
    int m_ptr;
    int m_hold;
    bit m_pre;

    mux32_rr_arbiter #(.MAX_HOLD(MAXH)) dut (
        .clock   (clock),
        .reset   (reset),
        .req     (req),
        .select  (select),
        .grant   (grant),
        .valid   (valid),
        .preempt (preempt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic int pick(input logic [31:0] r, input int p);
        for (int k = 0; k < 32; k++) begin
            if (r[(p + k) % 32]) return (p + k) % 32;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_hold  = 0;
        m_pre   = 0;
    endtask

    task automatic model_step(input logic [31:0] r);
        logic [31:0] oth;
        int o;
        m_pre = 0;
        if (m_owner < 0) begin
            if (r != 0) begin
                m_owner = pick(r, m_ptr);
                m_hold  = 0;
            end
        end else begin
            o   = m_owner;
            oth = r;
            oth[o] = 1'b0;
            if (!r[o]) begin
                m_ptr  = (o + 1) % 32;
                m_hold = 0;
                m_owner = (oth != 0) ? pick(oth, m_ptr) : -1;
            end else if (oth != 0 && m_hold == MAXH - 1) begin
                m_ptr   = (o + 1) % 32;
                m_owner = pick(oth, m_ptr);
                m_hold  = 0;
                m_pre   = 1;
            end else begin
                m_hold = (oth != 0) ? m_hold + 1 : 0;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [31:0] eg;
        eg = 32'h0;
        if (m_owner >= 0) eg[m_owner] = 1'b1;
        chk({tag, ".valid"}, {31'b0, valid}, {31'b0, m_owner >= 0});
        chk({tag, ".select"}, {27'b0, select},
            (m_owner >= 0) ? 32'(m_owner) : 32'h0);
        chk({tag, ".grant"}, grant, eg);
        chk({tag, ".preempt"}, {31'b0, preempt}, {31'b0, m_pre});
    endtask

    task automatic do_cycle(input string tag, input logic [31:0] r);
        req = r;
        @(posedge clock);
        model_step(r);
        #1;
        check_all(tag);
    endtask

    task automatic async_reset(input string tag);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_all({tag, ".async"});
        @(posedge clock);
        #1;
        check_all({tag, ".held"});
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        logic [31:0] r;
        int len;
        reset = 1'b0;
        req   = 32'h0;
        model_reset();
        #1;
        check_all("rst");
        repeat (2) @(posedge clock);
        #1;
        check_all("rst_clk");
        @(negedge clock);
        reset = 1'b1;

        // first grant and release
        do_cycle("t1_grant", 32'h0000_0010);
        chk("t1_sel4", {27'b0, select}, 32'd4);
        do_cycle("t1_drop", 32'h0);
        chk("t1_idle", {31'b0, valid}, 32'd0);

        // hold timeout rotation 4 -> 2
        do_cycle("t2_own4", 32'h0000_0010);
        for (int i = 0; i < 20; i++) begin
            do_cycle("t2_hold", 32'h0000_0014);
            if (i == 7) begin
                chk("t2_sel2", {27'b0, select}, 32'd2);
                chk("t2_pre", {31'b0, preempt}, 32'd1);
            end
        end
        do_cycle("t2_drop", 32'h0);

        // pointer wrap 30 -> 31 -> 0
        do_cycle("t3_own30", 32'h4000_0000);
        do_cycle("t3_to31", 32'h8000_0001);
        chk("t3_sel31", {27'b0, select}, 32'd31);
        do_cycle("t3_hold31", 32'h8000_0001);
        do_cycle("t3_to0", 32'h0000_0001);
        chk("t3_sel0", {27'b0, select}, 32'd0);
        do_cycle("t3_drop", 32'h0);

        // bubble-free handoff 7 -> 8
        do_cycle("t4_own7", 32'h0000_0080);
        repeat (3) do_cycle("t4_both", 32'h0000_0180);
        do_cycle("t4_hand", 32'h0000_0100);
        chk("t4_sel8", {27'b0, select}, 32'd8);
        chk("t4_valid", {31'b0, valid}, 32'd1);

        // lone owner holds indefinitely
        for (int i = 0; i < 50; i++) do_cycle("t5_lone", 32'h0000_0008);
        do_cycle("t5_drop", 32'h0);

        // async reset mid-grant, then restart from pointer 0
        do_cycle("t6_own12", 32'h0000_1000);
        do_cycle("t6_hold", 32'h0000_1000);
        async_reset("t6");
        do_cycle("t6_rel", 32'h1000_1000);
        chk("t6_sel12", {27'b0, select}, 32'd12);

        // random bursts of stable request patterns
        for (int b = 0; b < 60; b++) begin
            r = $urandom & $urandom;
            if ($urandom_range(0, 3) == 0) r = r & 32'h0000_000F;
            if ($urandom_range(0, 7) == 0) r = 32'h0;
            len = $urandom_range(1, 12);
            for (int c = 0; c < len; c++) do_cycle("rand", r);
            if (b == 30) async_reset("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
